// File: rtl/decode_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_seq_if
// Function : fetch, data-memory and register-file control bundle for decode_seq
// Revision : 1.0 - initial release
// ============================================================================
interface decode_seq_if;
   logic        instr_req;
   logic [11:0] instr_addr;
   logic        instr_ack;
   logic [15:0] instr;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ack;
   logic [11:0] pcAddData;
   logic        regEnable;
   logic        litEnable;
   logic        memEnable;
   logic [3:0]  SA;
   logic [3:0]  SB;
   logic [7:0]  lit;
   logic        halted;
   logic        illegal;

   // master = sequencer side
   modport master (
      output instr_req, instr_addr, mem_req, mem_we,
      output regEnable, litEnable, memEnable, SA, SB, lit, halted, illegal,
      input  instr_ack, instr, mem_ack, pcAddData
   );

   modport slave (
      input  instr_req, instr_addr, mem_req, mem_we,
      input  regEnable, litEnable, memEnable, SA, SB, lit, halted, illegal,
      output instr_ack, instr, mem_ack, pcAddData
   );
endinterface
`default_nettype wire

// File: rtl/decode_seq.sv
`default_nettype none
// ============================================================================
// Module   : decode_seq
// Function : fetch/decode/execute sequencer driving register-file write controls
// Revision : 1.0 - initial release
// ============================================================================
module decode_seq (
   input  wire logic     clk,
   input  wire logic     reset,
   decode_seq_if.master  bus
);

   localparam logic [3:0]  c_OP_NOP  = 4'h0;
   localparam logic [3:0]  c_OP_MOV  = 4'h1;
   localparam logic [3:0]  c_OP_LDI  = 4'h2;
   localparam logic [3:0]  c_OP_LD   = 4'h3;
   localparam logic [3:0]  c_OP_ST   = 4'h4;
   localparam logic [3:0]  c_OP_JMP  = 4'h5;
   localparam logic [3:0]  c_OP_HALT = 4'hF;
   localparam logic [11:0] c_PC_ONE  = 12'h001;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEMWAIT = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [11:0] r_pc;
   logic [11:0] w_pc_next;
   logic [15:0] r_ir;
   logic [3:0]  w_opcode;
   logic        w_ir_load;

   assign w_opcode       = r_ir[15:12];
   assign w_ir_load      = (r_state == S_FETCH) && bus.instr_ack;
   assign bus.instr_addr = r_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_pc    <= 12'h000;
         r_ir    <= 16'h0000;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_pc_next;
         if (w_ir_load) begin
            r_ir <= bus.instr;
         end
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_pc_next     = r_pc;
      bus.instr_req = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.regEnable = 1'b0;
      bus.litEnable = 1'b0;
      bus.memEnable = 1'b0;
      bus.SA        = 4'h0;
      bus.SB        = 4'h0;
      bus.lit       = 8'h00;
      bus.halted    = 1'b0;
      bus.illegal   = 1'b0;

      // Select fields are presented from DECODE until the next fetch
      if ((r_state == S_DECODE) || (r_state == S_EXEC) ||
          (r_state == S_MEMWAIT) || (r_state == S_WB)) begin
         bus.SA  = r_ir[11:8];
         bus.SB  = r_ir[7:4];
         bus.lit = r_ir[7:0];
      end

      case (r_state)
         S_FETCH: begin
            bus.instr_req = 1'b1;
            if (bus.instr_ack) begin
               w_next_state = S_DECODE;
            end
         end

         S_DECODE: begin
            w_next_state = S_EXEC;
         end

         S_EXEC: begin
            case (w_opcode)
               c_OP_NOP: begin
                  w_pc_next    = r_pc + c_PC_ONE;
                  w_next_state = S_FETCH;
               end
               c_OP_MOV: begin
                  bus.regEnable = 1'b1;
                  w_pc_next     = r_pc + c_PC_ONE;
                  w_next_state  = S_FETCH;
               end
               c_OP_LDI: begin
                  bus.regEnable = 1'b1;
                  bus.litEnable = 1'b1;
                  w_pc_next     = r_pc + c_PC_ONE;
                  w_next_state  = S_FETCH;
               end
               c_OP_LD, c_OP_ST: begin
                  w_next_state = S_MEMWAIT;
               end
               c_OP_JMP: begin
                  w_pc_next    = bus.pcAddData;
                  w_next_state = S_FETCH;
               end
               c_OP_HALT: begin
                  w_next_state = S_HALT;
               end
               default: begin
                  bus.illegal  = 1'b1;
                  w_pc_next    = r_pc + c_PC_ONE;
                  w_next_state = S_FETCH;
               end
            endcase
         end

         S_MEMWAIT: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = (w_opcode == c_OP_ST);
            if (bus.mem_ack) begin
               if (w_opcode == c_OP_ST) begin
                  w_pc_next    = r_pc + c_PC_ONE;
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_WB;
               end
            end
         end

         S_WB: begin
            bus.regEnable = 1'b1;
            bus.memEnable = 1'b1;
            w_pc_next     = r_pc + c_PC_ONE;
            w_next_state  = S_FETCH;
         end

         S_HALT: begin
            bus.halted = 1'b1;
         end

         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_seq
// Function : directed self-checking bench for decode_seq
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_seq;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   decode_seq_if bus ();

   decode_seq u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction with ack in FETCH; returns sampling in DECODE
   task automatic fetch(input logic [15:0] word);
      int n = 0;
      while (!bus.instr_req && n < 20) begin
         tick();
         n++;
      end
      chk("fetch_req", {31'd0, bus.instr_req}, 32'd1);
      bus.instr     = word;
      bus.instr_ack = 1'b1;
      tick();
      bus.instr_ack = 1'b0;
   endtask

   task automatic chk_en(input string tag, input logic r, input logic l, input logic m);
      chk(tag, {29'd0, bus.regEnable, bus.litEnable, bus.memEnable}, {29'd0, r, l, m});
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      reset         = 1'b1;
      bus.instr_ack = 1'b0;
      bus.instr     = 16'h0000;
      bus.mem_ack   = 1'b0;
      bus.pcAddData = 12'h000;
      tick();
      tick();
      chk_en("rst_en", 1'b0, 1'b0, 1'b0);
      chk("rst_memreq", {31'd0, bus.mem_req}, 32'd0);
      reset = 1'b0;
      chk("rst_req", {31'd0, bus.instr_req}, 32'd1);
      chk("rst_addr", {20'd0, bus.instr_addr}, 32'h000);
      chk("rst_halted", {31'd0, bus.halted}, 32'd0);

      // LDI
      fetch(16'h2A5C);
      chk("ldi_dec_lit", {24'd0, bus.lit}, 32'h5C);
      chk_en("ldi_dec_en", 1'b0, 1'b0, 1'b0);
      tick();
      chk_en("ldi_exec_en", 1'b1, 1'b1, 1'b0);
      chk("ldi_exec_lit", {24'd0, bus.lit}, 32'h5C);
      tick();
      chk_en("ldi_after_en", 1'b0, 1'b0, 1'b0);
      chk("ldi_next_addr", {20'd0, bus.instr_addr}, 32'h001);
      chk("ldi_next_req", {31'd0, bus.instr_req}, 32'd1);

      // MOV; a stray mem_ack outside MEMWAIT must be ignored
      fetch(16'h1370);
      chk("mov_dec_sa", {28'd0, bus.SA}, 32'h3);
      chk("mov_dec_sb", {28'd0, bus.SB}, 32'h7);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk_en("mov_exec_en", 1'b1, 1'b0, 1'b0);
      chk("mov_exec_sa", {28'd0, bus.SA}, 32'h3);
      tick();
      chk_en("mov_after_en", 1'b0, 1'b0, 1'b0);
      chk("mov_next_addr", {20'd0, bus.instr_addr}, 32'h002);

      // LD with mem_ack in the sixth request cycle; stray instr_ack ignored
      fetch(16'h3000);
      tick();
      chk("ld_exec_memreq", {31'd0, bus.mem_req}, 32'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("ld_wait_memreq", {31'd0, bus.mem_req}, 32'd1);
         chk("ld_wait_we", {31'd0, bus.mem_we}, 32'd0);
         chk_en("ld_wait_en", 1'b0, 1'b0, 1'b0);
         bus.instr_ack = (i == 2);
         bus.mem_ack   = (i == 5);
         tick();
      end
      bus.instr_ack = 1'b0;
      bus.mem_ack   = 1'b0;
      chk_en("ld_wb_en", 1'b1, 1'b0, 1'b1);
      chk("ld_wb_memreq", {31'd0, bus.mem_req}, 32'd0);
      tick();
      chk_en("ld_after_en", 1'b0, 1'b0, 1'b0);
      chk("ld_next_addr", {20'd0, bus.instr_addr}, 32'h003);

      // ST with immediate ack
      fetch(16'h4560);
      tick();
      tick();
      chk("st_memreq", {31'd0, bus.mem_req}, 32'd1);
      chk("st_we", {31'd0, bus.mem_we}, 32'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk_en("st_after_en", 1'b0, 1'b0, 1'b0);
      chk("st_next_addr", {20'd0, bus.instr_addr}, 32'h004);
      chk("st_next_req", {31'd0, bus.instr_req}, 32'd1);

      // JMP then wrap from 0xFFF
      bus.pcAddData = 12'h7FF;
      fetch(16'h5000);
      tick();
      chk_en("jmp_exec_en", 1'b0, 1'b0, 1'b0);
      tick();
      chk("jmp_addr", {20'd0, bus.instr_addr}, 32'h7FF);
      bus.pcAddData = 12'hFFF;
      fetch(16'h5000);
      tick();
      tick();
      chk("jmp_fff_addr", {20'd0, bus.instr_addr}, 32'hFFF);
      fetch(16'h0000);
      tick();
      chk_en("nop_exec_en", 1'b0, 1'b0, 1'b0);
      tick();
      chk("wrap_addr", {20'd0, bus.instr_addr}, 32'h000);

      // Undefined opcode
      fetch(16'h9000);
      chk("ill_dec", {31'd0, bus.illegal}, 32'd0);
      tick();
      chk("ill_exec", {31'd0, bus.illegal}, 32'd1);
      chk_en("ill_exec_en", 1'b0, 1'b0, 1'b0);
      tick();
      chk("ill_after", {31'd0, bus.illegal}, 32'd0);
      chk("ill_next_addr", {20'd0, bus.instr_addr}, 32'h001);

      // HALT is absorbing
      fetch(16'hF000);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("halt_flag", {31'd0, bus.halted}, 32'd1);
         chk("halt_req", {30'd0, bus.instr_req, bus.mem_req}, 32'd0);
         bus.instr_ack = 1'b1;
         tick();
      end
      bus.instr_ack = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("halt_rst_flag", {31'd0, bus.halted}, 32'd0);
      chk("halt_rst_addr", {20'd0, bus.instr_addr}, 32'h000);
      chk("halt_rst_req", {31'd0, bus.instr_req}, 32'd1);

      // Reset during a store's MEMWAIT
      fetch(16'h1000);
      tick();
      tick();
      fetch(16'h4000);
      tick();
      tick();
      chk("strst_memreq", {31'd0, bus.mem_req}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("strst_memreq_drop", {31'd0, bus.mem_req}, 32'd0);
      chk("strst_addr", {20'd0, bus.instr_addr}, 32'h000);
      chk("strst_req", {31'd0, bus.instr_req}, 32'd1);

      // Reset during LD writeback suppresses the regEnable pulse
      fetch(16'h3000);
      tick();
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk_en("ldrst_wb_en", 1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_en("ldrst_en", 1'b0, 1'b0, 1'b0);
      chk("ldrst_addr", {20'd0, bus.instr_addr}, 32'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_seq.md
DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 instr_req  output  1  instruction fetch request; held high until instr_ack.
REQ-004 instr_addr  output  12  fetch address, equal to the PC.
REQ-005 instr_ack  input  1  fetch complete; instr valid in the same cycle.
REQ-006 instr  input  16  instruction word: [15:12] opcode, [11:8] SA field, [7:4] SB field, [7:0] literal.
REQ-007 mem_req  output  1  data-memory request; held high until mem_ack.
REQ-008 mem_we  output  1  1 = store, 0 = load; valid while mem_req is high.
REQ-009 mem_ack  input  1  data-memory transfer complete.
REQ-010 pcAddData  input  12  jump/memory address from the register file (r13[3:0], r12).
REQ-011 regEnable, litEnable, memEnable  output  1 each  register-file write controls.
REQ-012 SA, SB  output  4 each  register-file select fields.
REQ-013 lit  output  8  literal value to the register file.
REQ-014 halted  output  1  sequencer is stopped in HALT.
REQ-015 illegal  output  1  one-cycle pulse when an undefined opcode is decoded.

Function
REQ-016 FSM states SHALL be: FETCH, DECODE, EXEC, MEMWAIT, WB, HALT.
REQ-017 FETCH: instr_req=1 and instr_addr=PC; on instr_ack, latch instr into IR and go to DECODE; otherwise stay in FETCH.
REQ-018 DECODE: one cycle; SA=IR[11:8], SB=IR[7:4], lit=IR[7:0] from DECODE until the next FETCH; next state is EXEC.
REQ-019 Opcode 0x0 NOP: in EXEC, PC<=PC+1 and go to FETCH; no write enables asserted.
REQ-020 Opcode 0x1 MOV/ALU writeback: in EXEC, regEnable=1, litEnable=0, memEnable=0 for exactly one cycle; PC<=PC+1; go to FETCH.
REQ-021 Opcode 0x2 LDI: in EXEC, regEnable=1, litEnable=1 for exactly one cycle (register-file target is r14); PC<=PC+1; go to FETCH.
REQ-022 Opcode 0x3 LD: EXEC goes to MEMWAIT with mem_req=1, mem_we=0; on mem_ack go to WB; WB asserts regEnable=1, memEnable=1 for one cycle (target r15); PC<=PC+1; go to FETCH.
REQ-023 Opcode 0x4 ST: EXEC goes to MEMWAIT with mem_req=1, mem_we=1; on mem_ack, PC<=PC+1 and go to FETCH; no register write is performed.
REQ-024 Opcode 0x5 JMP: in EXEC, PC<=pcAddData; go to FETCH.
REQ-025 Opcode 0xF HALT: in EXEC go to HALT; HALT is absorbing until reset, with halted=1 and all requests and enables at 0.
REQ-026 Opcodes 0x6-0xE: treated as NOP; illegal=1 for the EXEC cycle only.
REQ-027 Write enables SHALL never be high outside EXEC or WB, and at most one of litEnable/memEnable is high at a time.
REQ-028 The PC is 12 bits and wraps from 0xFFF to 0x000 with no flag.
REQ-029 instr_ack outside FETCH and mem_ack outside MEMWAIT SHALL be ignored.
REQ-030 Latency: NOP, MOV, LDI and JMP take 3 cycles from the FETCH ack cycle back to FETCH; LD takes 4 + memory wait cycles; ST takes 3 + memory wait cycles.

Reset
REQ-031 While reset=1 at a clock edge: state=FETCH, PC=0x000, IR=0, and all outputs go to 0 on the next cycle except instr_req and instr_addr.
REQ-032 After reset is released, instr_req=1 with instr_addr=0x000 in the first cycle.
REQ-033 Reset during MEMWAIT or WB aborts the transfer: mem_req drops to 0 and no regEnable pulse is issued.
REQ-034 Reset overrides HALT.

Verification
REQ-035 Reset, then instr=0x2A5C acked -> exactly one cycle with regEnable=1, litEnable=1, lit=0x5C; next instr_addr=0x001.
REQ-036 instr=0x1370 -> one cycle with regEnable=1, SA=3, litEnable=0, memEnable=0; PC increments.
REQ-037 instr=0x3000 with mem_ack delayed 5 cycles -> mem_req high for 6 cycles, mem_we=0, then one cycle of regEnable=1 with memEnable=1.
REQ-038 instr=0x5000 with pcAddData=0x7FF -> next instr_addr=0x7FF; PC=0xFFF executing NOP -> next instr_addr=0x000.
REQ-039 instr=0x9000 -> illegal pulses for 1 cycle, no enables, PC+1; instr=0xF000 -> halted=1 indefinitely, instr_req=0; reset -> instr_addr=0x000.
REQ-040 Reset asserted during MEMWAIT of a store -> mem_req=0 next cycle, then FETCH at 0x000.
